// File: rtl/camera_reg_seq_if.sv
// rtl/camera_reg_seq_if.sv - table-lookup and SCCB write handshake bundle for camera_reg_seq
//
// Signals:
//   reg_index   sequencer -> table : 9-bit table index (registered)
//   lut_data    table -> sequencer : {addr[15:0], data[7:0]} entry for reg_index
//   sccb_req    sequencer -> SCCB  : write request, held until ack or err
//   sccb_addr   sequencer -> SCCB  : 16-bit register address
//   sccb_wdata  sequencer -> SCCB  : 8-bit register data
//   sccb_ack    SCCB -> sequencer  : one-cycle pulse, write completed
//   sccb_err    SCCB -> sequencer  : one-cycle pulse, write NACKed
interface camera_reg_seq_if;
    logic [8:0]  reg_index;
    logic [23:0] lut_data;
    logic        sccb_req;
    logic [15:0] sccb_addr;
    logic [7:0]  sccb_wdata;
    logic        sccb_ack;
    logic        sccb_err;

    modport master (
        output reg_index,
        output sccb_req,
        output sccb_addr,
        output sccb_wdata,
        input  lut_data,
        input  sccb_ack,
        input  sccb_err
    );

    modport slave (
        input  reg_index,
        input  sccb_req,
        input  sccb_addr,
        input  sccb_wdata,
        output lut_data,
        output sccb_ack,
        output sccb_err
    );
endinterface

// File: rtl/camera_reg_seq.sv
// rtl/camera_reg_seq.sv - per-camera register-load sequencer driving an SCCB write master
//
// Walks a register table from index 0 to REG_NUM-1 after a power-up wait,
// issuing one SCCB write per entry. Entries with address 16'hFFFF are delay
// entries: they wait data*DLY_UNIT cycles instead of writing. A NACKed write is
// re-sent up to MAX_RETRY times before the sequencer parks in ERROR.
//
// Ports:
//   sys_clk      clock, rising edge
//   sys_rst_n    synchronous active-low reset
//   start        one-cycle pulse, begins a load (IDLE only)
//   bus          camera_reg_seq_if.master: table lookup + SCCB handshake
//   config_done  sticky, table fully written (cleared by reset only)
//   config_err   sticky, retries exhausted (cleared by reset only)
//   busy         high in every state except IDLE, DONE and ERROR
module camera_reg_seq #(
    parameter logic [8:0]  REG_NUM   = 9'd256,
    parameter logic [23:0] PWR_DLY   = 24'd10_000_000,
    parameter logic [15:0] DLY_UNIT  = 16'd50_000,
    parameter logic [1:0]  MAX_RETRY = 2'd3
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    start,
    camera_reg_seq_if.master        bus,
    output logic                    config_done,
    output logic                    config_err,
    output logic                    busy
);

    typedef enum logic [3:0] {
        IDLE,
        PWR_WAIT,
        FETCH,
        ISSUE,
        WAIT_ACK,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [23:0] cnt;
    logic [23:0] dly_target;
    logic [1:0]  retry;

    logic pwr_last;
    logic dly_last;
    logic is_delay_entry;
    logic last_index;

    // A zero-length wait still spends one cycle in its state.
    assign pwr_last       = (PWR_DLY == 24'd0) || (cnt == PWR_DLY - 24'd1);
    assign dly_last       = (dly_target == 24'd0) || (cnt == dly_target - 24'd1);
    assign is_delay_entry = (bus.lut_data[23:8] == 16'hFFFF);
    assign last_index     = (bus.reg_index == REG_NUM - 9'd1);

    assign busy        = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign config_done = (state == DONE);
    assign config_err  = (state == ERROR);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = PWR_WAIT;
            PWR_WAIT: if (pwr_last) state_next = FETCH;
            FETCH:    state_next = is_delay_entry ? DELAY : ISSUE;
            ISSUE:    state_next = WAIT_ACK;
            WAIT_ACK: begin
                // ack wins over a simultaneous err
                if (bus.sccb_ack) begin
                    state_next = NEXT;
                end else if (bus.sccb_err) begin
                    state_next = (retry == MAX_RETRY) ? ERROR : ISSUE;
                end
            end
            DELAY:    if (dly_last) state_next = NEXT;
            NEXT:     state_next = last_index ? DONE : FETCH;
            DONE:     state_next = DONE;
            ERROR:    state_next = ERROR;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt            <= '0;
            dly_target     <= '0;
            retry          <= '0;
            bus.reg_index  <= '0;
            bus.sccb_addr  <= '0;
            bus.sccb_wdata <= '0;
            bus.sccb_req   <= 1'b0;
        end else begin
            // A fresh entry raises req already in ISSUE; a retry drops req for
            // the ISSUE cycle so each re-send is a distinct request edge.
            bus.sccb_req <= ((state == FETCH) && (state_next == ISSUE))
                            || (state_next == WAIT_ACK);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt           <= '0;
                        retry         <= '0;
                        bus.reg_index <= '0;
                    end
                end
                PWR_WAIT: cnt <= cnt + 24'd1;
                FETCH: begin
                    cnt <= '0;
                    if (is_delay_entry) begin
                        // 8x16-bit product always fits in 24 bits
                        dly_target <= 24'(bus.lut_data[7:0]) * 24'(DLY_UNIT);
                    end else begin
                        bus.sccb_addr  <= bus.lut_data[23:8];
                        bus.sccb_wdata <= bus.lut_data[7:0];
                    end
                end
                WAIT_ACK: begin
                    if (bus.sccb_ack) begin
                        retry <= '0;
                    end else if (bus.sccb_err && (retry != MAX_RETRY)) begin
                        retry <= retry + 2'd1;
                    end
                end
                DELAY: cnt <= cnt + 24'd1;
                NEXT: begin
                    if (!last_index) begin
                        bus.reg_index <= bus.reg_index + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_reg_seq.sv
// tb/tb_camera_reg_seq.sv - directed self-checking bench for camera_reg_seq
module tb_camera_reg_seq;

    logic clk;
    logic rst_n;
    logic start;
    logic config_done;
    logic config_err;
    logic busy;

    int tests = 0;
    int fails = 0;

    logic [23:0] tbl [0:511];

    camera_reg_seq_if bus ();

    assign bus.lut_data = tbl[bus.reg_index];

    camera_reg_seq #(
        .REG_NUM   (9'd3),
        .PWR_DLY   (24'd4),
        .DLY_UNIT  (16'd10),
        .MAX_RETRY (2'd3)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .start       (start),
        .bus         (bus),
        .config_done (config_done),
        .config_err  (config_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        bus.sccb_ack = 1'b0;
        bus.sccb_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_table_a();
        tbl[0] = 24'h3012_01;
        tbl[1] = 24'h0100_01;
        tbl[2] = 24'h3501_20;
    endtask

    // Leaves the bench on the first negedge after the start edge (edge count 1).
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns n = negedge count (current negedge = 1) at which req was seen.
    task automatic wait_req(output logic got, output int n);
        n = 1;
        while (bus.sccb_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = (bus.sccb_req === 1'b1);
    endtask

    // mode 0: ack, 1: err, 2: ack and err together
    task automatic do_write(input int mode, output logic got, output int n,
                            output logic [15:0] a, output logic [7:0] d,
                            output logic [8:0] idx);
        wait_req(got, n);
        a   = bus.sccb_addr;
        d   = bus.sccb_wdata;
        idx = bus.reg_index;
        if (got) begin
            repeat (4) @(negedge clk);
            check("req_held", bus.sccb_req, 1);
            bus.sccb_ack = (mode != 1);
            bus.sccb_err = (mode != 0);
            @(negedge clk);
            bus.sccb_ack = 1'b0;
            bus.sccb_err = 1'b0;
            check("req_drop", bus.sccb_req, 0);
        end
    endtask

    task automatic check_write(input string tag, input int mode,
                               input logic [15:0] ea, input logic [7:0] ed,
                               input logic [8:0] eidx);
        logic        got;
        int          n;
        logic [15:0] a;
        logic [7:0]  d;
        logic [8:0]  idx;
        do_write(mode, got, n, a, d, idx);
        check({tag, "_got"}, got, 1);
        check({tag, "_addr"}, a, ea);
        check({tag, "_data"}, d, ed);
        check({tag, "_idx"}, idx, eidx);
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, config_done, 1);
        check({tag, "_err"}, config_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req"}, bus.sccb_req, 0);
        check({tag, "_idx"}, bus.reg_index, 2);
    endtask

    initial begin
        logic        got;
        int          n;
        logic [15:0] a;
        logic [7:0]  d;
        logic [8:0]  idx;
        logic        seen;

        rst_n = 1'b0;
        start = 1'b0;
        bus.sccb_ack = 1'b0;
        bus.sccb_err = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_idx", bus.reg_index, 0);
        check("rst_req", bus.sccb_req, 0);
        check("rst_addr", bus.sccb_addr, 0);
        check("rst_wdata", bus.sccb_wdata, 0);
        check("rst_done", config_done, 0);
        check("rst_err", config_err, 0);
        check("rst_busy", busy, 0);

        // Basic three-entry load, spurious start/ack during the run
        load_table_a();
        start_pulse();
        check("a_busy", busy, 1);
        do_write(0, got, n, a, d, idx);
        check("a0_got", got, 1);
        check("a0_latency", n, 6);
        check("a0_addr", a, 16'h3012);
        check("a0_data", d, 8'h01);
        check("a0_idx", idx, 0);
        @(negedge clk);                 // FETCH of index 1
        bus.sccb_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);                 // ISSUE of index 1
        bus.sccb_ack = 1'b0;
        start = 1'b0;
        check("a_spur_idx", bus.reg_index, 1);
        check("a_spur_req", bus.sccb_req, 1);
        check_write("a1", 0, 16'h0100, 8'h01, 9'd1);
        check_write("a2", 0, 16'h3501, 8'h20, 9'd2);
        check_done("a");
        start_pulse();
        repeat (5) @(negedge clk);
        check("a_done_hold", config_done, 1);
        check("a_done_busy", busy, 0);

        // Delay entry: 2 units of 10 cycles
        do_reset();
        tbl[0] = 24'hFFFF_02;
        tbl[1] = 24'h0100_05;
        tbl[2] = 24'h1234_AA;
        start_pulse();
        do_write(0, got, n, a, d, idx);
        check("b1_got", got, 1);
        check("b1_latency", n, 28);
        check("b1_addr", a, 16'h0100);
        check("b1_data", d, 8'h05);
        check("b1_idx", idx, 1);
        check_write("b2", 0, 16'h1234, 8'hAA, 9'd2);
        check_done("b");

        // Three NACKs then ack on two entries; ack+err together on the last
        do_reset();
        load_table_a();
        start_pulse();
        for (int i = 0; i < 4; i++) check_write("c0", (i < 3) ? 1 : 0, 16'h3012, 8'h01, 9'd0);
        for (int i = 0; i < 4; i++) check_write("c1", (i < 3) ? 1 : 0, 16'h0100, 8'h01, 9'd1);
        check_write("c2", 2, 16'h3501, 8'h20, 9'd2);
        check_done("c");

        // Four NACKs exhaust retries
        do_reset();
        load_table_a();
        start_pulse();
        for (int i = 0; i < 4; i++) check_write("d0", 1, 16'h3012, 8'h01, 9'd0);
        check("d_err", config_err, 1);
        check("d_done", config_done, 0);
        check("d_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sccb_req === 1'b1) seen = 1'b1;
        end
        check("d_no_req", seen, 0);
        check("d_err_hold", config_err, 1);

        // Reset in the middle of a handshake, then a clean restart
        do_reset();
        load_table_a();
        start_pulse();
        check_write("e0", 0, 16'h3012, 8'h01, 9'd0);
        wait_req(got, n);
        check("e1_got", got, 1);
        check("e1_idx", bus.reg_index, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("e_rst_req", bus.sccb_req, 0);
        check("e_rst_idx", bus.reg_index, 0);
        check("e_rst_addr", bus.sccb_addr, 0);
        check("e_rst_wdata", bus.sccb_wdata, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_done", config_done, 0);
        rst_n = 1'b1;
        start_pulse();
        do_write(0, got, n, a, d, idx);
        check("e_re_got", got, 1);
        check("e_re_latency", n, 6);
        check("e_re_addr", a, 16'h3012);
        check("e_re_idx", idx, 0);
        check_write("e_re1", 0, 16'h0100, 8'h01, 9'd1);
        check_write("e_re2", 0, 16'h3501, 8'h20, 9'd2);
        check_done("e");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
